// File: rtl/melody_recorder.sv
// Sits between piano_keypad and pitch_generator: registered live passthrough,
// run-length recording of the live note stream, and gapless playback of the buffer.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | live passthrough; waits for rec_start / play_start
// RECORD | live passthrough; segments of constant (note, octave) are buffered
// PLAY   | buffer entries drive note/octave, each held d*TICK_DIV cycles
module melody_recorder #(
   parameter int DEPTH    = 64,
   parameter int TICK_DIV = 1000000,
   parameter int DUR_W    = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [3:0]                 live_note,
   input  logic [3:0]                 live_octave,
   input  logic                       rec_start,
   input  logic                       play_start,
   input  logic                       stop,
   output logic [3:0]                 note,
   output logic [3:0]                 octave,
   output logic [1:0]                 state,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int TW = $clog2(TICK_DIV + 1);
   localparam int EW = 8 + DUR_W;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RECORD = 2'd1;
   localparam logic [1:0] ST_PLAY   = 2'd2;

   localparam logic [DUR_W-1:0] DUR_MAX   = '1;
   localparam logic [DUR_W-1:0] DUR_SAT   = DUR_MAX - DUR_W'(1);
   localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);
   localparam logic [CW-1:0]    LAST_SLOT = CW'(DEPTH - 1);

   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic              full_q, full_d;
   logic [3:0]        note_q, note_d;
   logic [3:0]        octave_q, octave_d;
   logic [TW-1:0]     tick_q, tick_d;
   logic [DUR_W-1:0]  dur_q, dur_d;
   logic [3:0]        cur_note_q, cur_note_d;
   logic [3:0]        cur_oct_q, cur_oct_d;
   logic [CW-1:0]     ptr_q, ptr_d;
   logic [DUR_W-1:0]  rem_q, rem_d;

   logic              wr_en;
   logic [DUR_W-1:0]  wr_dur;
   logic              tick_wrap;
   logic              pair_chg;
   logic              entry_done;

   logic [EW-1:0]     mem [DEPTH];
   logic [EW-1:0]     rd_q;
   logic [3:0]        rd_note;
   logic [3:0]        rd_oct;
   logic [DUR_W-1:0]  rd_dur;

   assign tick_wrap  = (tick_q == TICK_LAST);
   assign pair_chg   = (live_note != cur_note_q) || (live_octave != cur_oct_q);
   // rem_q==0 only right after play_start: nothing loaded yet, load entry 0 at once
   assign entry_done = (rem_q == '0) || (tick_wrap && (rem_q == DUR_W'(1)));

   assign rd_note = rd_q[EW-1 -: 4];
   assign rd_oct  = rd_q[DUR_W +: 4];
   assign rd_dur  = rd_q[DUR_W-1:0];

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      full_d     = full_q;
      note_d     = note_q;
      octave_d   = octave_q;
      tick_d     = tick_q;
      dur_d      = dur_q;
      cur_note_d = cur_note_q;
      cur_oct_d  = cur_oct_q;
      ptr_d      = ptr_q;
      rem_d      = rem_q;
      wr_en      = 1'b0;
      wr_dur     = dur_q;

      case (state_q)
         ST_IDLE: begin
            note_d   = live_note;
            octave_d = live_octave;
            if (!stop && rec_start) begin
               state_d    = ST_RECORD;
               count_d    = '0;
               full_d     = 1'b0;
               cur_note_d = live_note;
               cur_oct_d  = live_octave;
               dur_d      = '0;
               tick_d     = '0;
            end else if (!stop && play_start && (count_q != '0)) begin
               state_d = ST_PLAY;
               ptr_d   = '0;
               rem_d   = '0;
               tick_d  = '0;
            end
         end

         ST_RECORD: begin
            note_d   = live_note;
            octave_d = live_octave;
            if (stop) begin
               state_d = ST_IDLE;
               wr_en   = (dur_q != '0) && (count_q < DEPTH_C);
            end else if (pair_chg) begin
               // zero-tick segments are keypad glitches and are dropped
               wr_en      = (dur_q != '0);
               cur_note_d = live_note;
               cur_oct_d  = live_octave;
               dur_d      = '0;
               tick_d     = '0;
            end else if (tick_wrap) begin
               tick_d = '0;
               if (dur_q == DUR_SAT) begin
                  wr_en  = 1'b1;
                  wr_dur = DUR_MAX;
                  dur_d  = '0;
               end else begin
                  dur_d = dur_q + DUR_W'(1);
               end
            end else begin
               tick_d = tick_q + TW'(1);
            end
            if (wr_en) begin
               count_d = count_q + CW'(1);
               if (count_q == LAST_SLOT) begin
                  full_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end

         ST_PLAY: begin
            if (stop) begin
               state_d  = ST_IDLE;
               note_d   = live_note;
               octave_d = live_octave;
            end else if (entry_done) begin
               if (ptr_q == count_q) begin
                  state_d  = ST_IDLE;
                  note_d   = live_note;
                  octave_d = live_octave;
               end else begin
                  // rd_q already holds entry ptr_q, so the swap is gapless
                  note_d   = rd_note;
                  octave_d = rd_oct;
                  rem_d    = rd_dur;
                  tick_d   = '0;
                  ptr_d    = ptr_q + CW'(1);
               end
            end else if (tick_wrap) begin
               tick_d = '0;
               rem_d  = rem_q - DUR_W'(1);
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         full_q     <= 1'b0;
         note_q     <= '0;
         octave_q   <= '0;
         tick_q     <= '0;
         dur_q      <= '0;
         cur_note_q <= '0;
         cur_oct_q  <= '0;
         ptr_q      <= '0;
         rem_q      <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         full_q     <= full_d;
         note_q     <= note_d;
         octave_q   <= octave_d;
         tick_q     <= tick_d;
         dur_q      <= dur_d;
         cur_note_q <= cur_note_d;
         cur_oct_q  <= cur_oct_d;
         ptr_q      <= ptr_d;
         rem_q      <= rem_d;
      end
   end

   // read address follows ptr_d so rd_q always mirrors entry ptr_q
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[count_q[AW-1:0]] <= {cur_note_q, cur_oct_q, wr_dur};
      rd_q <= mem[ptr_d[AW-1:0]];
   end

   assign note   = note_q;
   assign octave = octave_q;
   assign state  = state_q;
   assign count  = count_q;
   assign full   = full_q;

endmodule

// File: tb/tb_melody_recorder.sv
// Directed bench for melody_recorder with TICK_DIV=4, DEPTH=4, DUR_W=3.
// Expected {state, note, octave} samples are queued when stimulus is driven.
module tb_melody_recorder;

   localparam int TD = 4;

   typedef struct packed {
      logic [3:0] n;
      logic [3:0] o;
      logic [2:0] d;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] live_note = '0;
   logic [3:0] live_octave = '0;
   logic       rec_start = 1'b0;
   logic       play_start = 1'b0;
   logic       stop = 1'b0;
   logic [3:0] note;
   logic [3:0] octave;
   logic [1:0] state;
   logic [2:0] count;
   logic       full;

   int n_checks = 0;
   int n_pass = 0;

   logic [9:0] sb[$];
   ent_t       ents[$];

   melody_recorder #(.DEPTH(4), .TICK_DIV(TD), .DUR_W(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .live_note(live_note), .live_octave(live_octave),
      .rec_start(rec_start), .play_start(play_start), .stop(stop),
      .note(note), .octave(octave), .state(state), .count(count), .full(full)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic sb_check(input string tag);
      logic [9:0] e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk(tag, {22'd0, state, note, octave}, {22'd0, e});
      end
   endtask

   task automatic live_step(input logic [3:0] n, input logic [3:0] o, input logic [1:0] st,
                            input string tag);
      live_note   = n;
      live_octave = o;
      sb.push_back({st, n, o});
      step();
      sb_check(tag);
   endtask

   task automatic pulse_rec();
      rec_start = 1'b1;
      step();
      rec_start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   // plays ents back and compares every cycle until the return to IDLE
   task automatic play_seq(input string tag);
      live_note   = 4'd9;
      live_octave = 4'd9;
      sb.push_back({2'd2, 4'd9, 4'd9});
      foreach (ents[k])
         for (int c = 0; c < ents[k].d * TD; c++)
            sb.push_back({2'd2, ents[k].n, ents[k].o});
      sb.push_back({2'd0, 4'd9, 4'd9});
      play_start = 1'b1;
      step();
      play_start = 1'b0;
      sb_check(tag);
      while (sb.size() != 0) begin
         step();
         sb_check(tag);
      end
   endtask

   initial begin
      step();
      step();
      chk("rst_note", 32'(note), 32'd0);
      chk("rst_octave", 32'(octave), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      rst_n = 1'b1;

      play_start = 1'b1;
      step();
      play_start = 1'b0;
      chk("play_empty_state", 32'(state), 32'd0);

      live_step(4'd5, 4'd4, 2'd0, "pass_a");
      chk("pass_count", 32'(count), 32'd0);
      live_step(4'd10, 4'd3, 2'd0, "pass_b");
      live_step(4'd5, 4'd4, 2'd0, "pass_c");

      // two segments: (5,4) for 3 ticks, rest (0,4) for 2 ticks
      pulse_rec();
      chk("rec1_state", 32'(state), 32'd1);
      chk("rec1_count0", 32'(count), 32'd0);
      repeat (12) step();
      live_step(4'd0, 4'd4, 2'd1, "rec1_live");
      chk("rec1_count1", 32'(count), 32'd1);
      repeat (8) step();
      pulse_stop();
      chk("rec1_state_end", 32'(state), 32'd0);
      chk("rec1_count", 32'(count), 32'd2);
      ents.delete();
      ents.push_back('{4'd5, 4'd4, 3'd3});
      ents.push_back('{4'd0, 4'd4, 3'd2});
      play_seq("play1");
      chk("play1_count", 32'(count), 32'd2);
      live_step(4'd1, 4'd2, 2'd0, "play1_after");

      // replay, interrupted by stop
      live_note = 4'd9; live_octave = 4'd9;
      play_start = 1'b1;
      step();
      play_start = 1'b0;
      step();
      chk("stopplay_note", 32'(note), 32'd5);
      step();
      pulse_stop();
      chk("stopplay_state", 32'(state), 32'd0);
      chk("stopplay_count", 32'(count), 32'd2);
      chk("stopplay_note_live", 32'(note), 32'd9);

      // glitch filter: 2-cycle (7,4) blip is dropped
      live_note = 4'd5; live_octave = 4'd4;
      pulse_rec();
      repeat (8) step();
      live_note = 4'd7;
      step();
      chk("glitch_count1", 32'(count), 32'd1);
      step();
      live_note = 4'd5;
      step();
      chk("glitch_count_disc", 32'(count), 32'd1);
      repeat (8) step();
      pulse_stop();
      chk("glitch_count", 32'(count), 32'd2);
      ents.delete();
      ents.push_back('{4'd5, 4'd4, 3'd2});
      ents.push_back('{4'd5, 4'd4, 3'd2});
      play_seq("play_glitch");

      // duration saturation at 7 ticks
      live_note = 4'd3; live_octave = 4'd5;
      pulse_rec();
      repeat (27) step();
      chk("sat_count27", 32'(count), 32'd0);
      step();
      chk("sat_count28", 32'(count), 32'd1);
      repeat (12) step();
      pulse_stop();
      chk("sat_count", 32'(count), 32'd2);
      ents.delete();
      ents.push_back('{4'd3, 4'd5, 3'd7});
      ents.push_back('{4'd3, 4'd5, 3'd3});
      play_seq("play_sat");

      // fill the buffer; fifth note is never stored
      live_note = 4'd1; live_octave = 4'd1;
      pulse_rec();
      repeat (8) step();
      for (int i = 0; i < 3; i++) begin
         live_note = 4'(i + 2);
         step();
         chk("fill_count", 32'(count), 32'(i + 1));
         repeat (8) step();
      end
      live_note = 4'd5;
      step();
      chk("fill_count4", 32'(count), 32'd4);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_state", 32'(state), 32'd0);
      repeat (8) step();
      chk("fill_count_hold", 32'(count), 32'd4);
      ents.delete();
      for (int i = 0; i < 4; i++) ents.push_back('{4'(i + 1), 4'd1, 3'd2});
      play_seq("play_fill");

      pulse_rec();
      chk("rerec_full", 32'(full), 32'd0);
      chk("rerec_count", 32'(count), 32'd0);
      chk("rerec_state", 32'(state), 32'd1);
      pulse_stop();
      chk("rerec_stop_count", 32'(count), 32'd0);

      // asynchronous reset mid-record
      live_note = 4'd6; live_octave = 4'd2;
      pulse_rec();
      repeat (9) step();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_state", 32'(state), 32'd0);
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_note", 32'(note), 32'd0);
      step();
      rst_n = 1'b1;
      play_start = 1'b1;
      step();
      play_start = 1'b0;
      chk("arst_play_state", 32'(state), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
